crc16_parallel_checker: RTL and testbench

CRC16_PARALLEL_CHECKER -- requirements
Module: crc16_parallel_checker

---
 rtl/crc16_pkg.sv | 14 +
 rtl/crc16_byte_next.sv | 26 ++
 rtl/crc16_parallel_checker.sv | 137 +++++++++++++
 tb/tb_crc16_parallel_checker.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/crc16_pkg.sv
// rtl/crc16_pkg.sv - CRC-16 (0x8005) checker constants and FSM state type
package crc16_pkg;

  localparam logic [15:0] CRC16_POLY    = 16'h8005;
  localparam logic [15:0] CRC16_INIT    = 16'h0000;
  localparam logic [15:0] MIN_FRAME_LEN = 16'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    CHECK = 2'd2
  } state_t;

endpackage

// File: rtl/crc16_byte_next.sv
// rtl/crc16_byte_next.sv - byte-wide MSB-first CRC-16 next-state XOR network
module crc16_byte_next
  import crc16_pkg::*;
(
  input  logic [15:0] crc,
  input  logic [7:0]  d,
  output logic [15:0] next
);

  logic [15:0] c;

  // Eight unrolled serial steps; synthesis flattens this into a pure XOR tree.
  always_comb begin
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      if (c[15] ^ d[i]) begin
        c = {c[14:0], 1'b0} ^ CRC16_POLY;
      end else begin
        c = {c[14:0], 1'b0};
      end
    end
  end

  assign next = c;

endmodule

// File: rtl/crc16_parallel_checker.sv
// rtl/crc16_parallel_checker.sv - frame CRC-16 checker; CRC16_CHK_STRIP_EN drops trailing CRC bytes from dout
module crc16_parallel_checker
  import crc16_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  din,
  input  logic        din_valid,
  input  logic        din_last,
  output logic        din_ready,
  output logic [7:0]  dout,
  output logic        dout_valid,
  output logic        frame_done,
  output logic        crc_ok,
  output logic        crc_err,
  output logic        len_err,
  output logic [15:0] crc_rem,
  output logic [15:0] frame_len
);

  state_t      state;
  logic [15:0] crc_reg;
  logic [15:0] count;
  logic [15:0] crc_in;
  logic [15:0] crc_next;
  logic        accept;
  logic        frame_good;

  assign din_ready  = (state != CHECK);
  assign accept     = din_valid && din_ready;
  assign crc_in     = (state == IDLE) ? CRC16_INIT : crc_reg;
  assign frame_good = (crc_reg == 16'h0000) && (count >= MIN_FRAME_LEN);

  crc16_byte_next u_byte_next (
    .crc  (crc_in),
    .d    (din),
    .next (crc_next)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      crc_reg    <= CRC16_INIT;
      count      <= 16'd0;
      frame_done <= 1'b0;
      crc_ok     <= 1'b0;
      crc_err    <= 1'b0;
      len_err    <= 1'b0;
      crc_rem    <= 16'd0;
      frame_len  <= 16'd0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            crc_reg <= crc_next;
            count   <= 16'd1;
            state   <= din_last ? CHECK : RECV;
          end
        end
        RECV: begin
          if (accept) begin
            crc_reg <= crc_next;
            if (count != 16'hFFFF) begin
              count <= count + 16'd1;
            end
            if (din_last) begin
              state <= CHECK;
            end
          end
        end
        CHECK: begin
          frame_done <= 1'b1;
          crc_ok     <= frame_good;
          crc_err    <= !frame_good;
          len_err    <= (count < MIN_FRAME_LEN);
          crc_rem    <= crc_reg;
          frame_len  <= count;
          crc_reg    <= CRC16_INIT;
          count      <= 16'd0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CRC16_CHK_STRIP_EN
  logic [7:0] hold_new;
  logic [7:0] hold_old;
  logic [1:0] fill;

  // A byte leaves only once two newer bytes exist, so the last two (the CRC) never do.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout       <= 8'd0;
      dout_valid <= 1'b0;
      hold_new   <= 8'd0;
      hold_old   <= 8'd0;
      fill       <= 2'd0;
    end else begin
      dout_valid <= 1'b0;
      if (accept) begin
        if (state == IDLE) begin
          hold_new <= din;
          hold_old <= 8'd0;
          fill     <= 2'd1;
        end else begin
          if (fill == 2'd2) begin
            dout       <= hold_old;
            dout_valid <= 1'b1;
          end else begin
            fill <= fill + 2'd1;
          end
          hold_old <= hold_new;
          hold_new <= din;
        end
      end else if (state == CHECK) begin
        fill <= 2'd0;
      end
    end
  end
`else
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout       <= 8'd0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= accept;
      if (accept) begin
        dout <= din;
      end
    end
  end
`endif

endmodule

// File: tb/tb_crc16_parallel_checker.sv
// tb/tb_crc16_parallel_checker.sv - self-checking bench for crc16_parallel_checker
module tb_crc16_parallel_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  din = 8'd0;
  logic        din_valid = 1'b0;
  logic        din_last = 1'b0;
  logic        din_ready;
  logic [7:0]  dout;
  logic        dout_valid;
  logic        frame_done;
  logic        crc_ok;
  logic        crc_err;
  logic        len_err;
  logic [15:0] crc_rem;
  logic [15:0] frame_len;

  crc16_parallel_checker dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .din_last   (din_last),
    .din_ready  (din_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .frame_done (frame_done),
    .crc_ok     (crc_ok),
    .crc_err    (crc_err),
    .len_err    (len_err),
    .crc_rem    (crc_rem),
    .frame_len  (frame_len)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        ok;
    logic        err;
    logic        lerr;
    logic [15:0] rem;
    logic [15:0] len;
  } stat_t;

  int          tests = 0;
  int          fails = 0;
  int          last_out_n = 0;
  logic [7:0]  out_q[$];
  logic [7:0]  exp_out[$];
  stat_t       stat_q[$];
  stat_t       exp_stat[$];

  always @(negedge clk) begin
    if (rst) begin
      if (dout_valid) out_q.push_back(dout);
      if (frame_done) stat_q.push_back({crc_ok, crc_err, len_err, crc_rem, frame_len});
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Remainder of M(x)*x^16 mod P(x) by textbook long division over the bit stream.
  function automatic logic [15:0] crc_model(input logic [7:0] m[$]);
    logic [16:0] r;
    logic        b;
    int          nbits;
    r = 17'd0;
    nbits = m.size() * 8 + 16;
    for (int k = 0; k < nbits; k++) begin
      b = (k < m.size() * 8) ? m[k / 8][7 - (k % 8)] : 1'b0;
      r = {r[15:0], b};
      if (r[16]) r = r ^ 17'h18005;
    end
    return r[15:0];
  endfunction

  task automatic model_frame(input logic [7:0] f[$]);
    logic [15:0] rem;
    logic [15:0] len;
    logic        ok;
    rem = crc_model(f);
    len = (f.size() > 65535) ? 16'hFFFF : 16'(f.size());
    ok  = (rem == 16'h0000) && (f.size() >= 3);
    exp_stat.push_back({ok, !ok, (f.size() < 3), rem, len});
`ifdef CRC16_CHK_STRIP_EN
    if (f.size() >= 3) for (int i = 0; i < f.size() - 2; i++) exp_out.push_back(f[i]);
`else
    foreach (f[i]) exp_out.push_back(f[i]);
`endif
  endtask

  task automatic send_frame(input logic [7:0] f[$], input bit gaps, output int stalls);
    logic rdy;
    stalls = 0;
    foreach (f[i]) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          din       = 8'($urandom);
          din_valid = 1'b0;
          din_last  = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
      end
      din       = f[i];
      din_valid = 1'b1;
      din_last  = (i == f.size() - 1);
      rdy = 1'b0;
      for (int w = 0; w < 20 && !rdy; w++) begin
        @(negedge clk);
        rdy = din_ready;
        @(posedge clk); #1;
        if (!rdy) stalls++;
      end
      if (!rdy) check("accept_timeout", 32'(rdy), 32'd1);
    end
    din_valid = 1'b0;
    din_last  = 1'b0;
  endtask

  task automatic verify(input string tag);
    stat_t got;
    stat_t want;
    int    n;
    for (int w = 0; w < 40 && stat_q.size() < exp_stat.size(); w++) begin
      @(posedge clk); #1;
    end
    repeat (2) begin
      @(posedge clk); #1;
    end
    check({tag, "_done_count"}, stat_q.size(), exp_stat.size());
    while (stat_q.size() > 0 && exp_stat.size() > 0) begin
      got  = stat_q.pop_front();
      want = exp_stat.pop_front();
      check({tag, "_crc_ok"},    32'(got.ok),   32'(want.ok));
      check({tag, "_crc_err"},   32'(got.err),  32'(want.err));
      check({tag, "_len_err"},   32'(got.lerr), 32'(want.lerr));
      check({tag, "_crc_rem"},   32'(got.rem),  32'(want.rem));
      check({tag, "_frame_len"}, 32'(got.len),  32'(want.len));
    end
    last_out_n = out_q.size();
    check({tag, "_dout_count"}, out_q.size(), exp_out.size());
    n = (out_q.size() < exp_out.size()) ? out_q.size() : exp_out.size();
    for (int i = 0; i < n; i++) check({tag, "_dout_byte"}, 32'(out_q[i]), 32'(exp_out[i]));
    out_q.delete();
    exp_out.delete();
    stat_q.delete();
    exp_stat.delete();
  endtask

  initial begin
    logic [7:0]  good[$];
    logic [7:0]  bad[$];
    logic [7:0]  one[$];
    logic [7:0]  rf[$];
    logic [15:0] c;
    int          s1;
    int          s2;

    good = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'hFE, 8'hE8};
    bad  = good;
    bad[4] = 8'h34;
    one  = '{8'h00};

    #12;
    check("rst_din_ready",  32'(din_ready),  32'd1);
    check("rst_dout_valid", 32'(dout_valid), 32'd0);
    check("rst_dout",       32'(dout),       32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_crc_ok",     32'(crc_ok),     32'd0);
    check("rst_crc_err",    32'(crc_err),    32'd0);
    check("rst_len_err",    32'(len_err),    32'd0);
    check("rst_crc_rem",    32'(crc_rem),    32'd0);
    check("rst_frame_len",  32'(frame_len),  32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    model_frame(good);
    send_frame(good, 1'b0, s1);
    verify("good");
`ifdef CRC16_CHK_STRIP_EN
    check("good_dout_pulses", last_out_n, 9);
`else
    check("good_dout_pulses", last_out_n, 11);
`endif
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("hold_crc_ok",    32'(crc_ok),    32'd1);
    check("hold_frame_len", 32'(frame_len), 32'd11);

    model_frame(bad);
    send_frame(bad, 1'b0, s1);
    verify("bad");
    check("bad_rem_nonzero", 32'(crc_rem != 16'h0000), 32'd1);

    model_frame(one);
    send_frame(one, 1'b0, s1);
    verify("short");
`ifdef CRC16_CHK_STRIP_EN
    check("short_dout_pulses", last_out_n, 0);
`else
    check("short_dout_pulses", last_out_n, 1);
`endif

    model_frame(good);
    model_frame(good);
    send_frame(good, 1'b0, s1);
    send_frame(good, 1'b0, s2);
    check("b2b_first_stall", s1, 0);
    check("b2b_check_stall", s2, 1);
    verify("b2b");

    for (int i = 0; i < 4; i++) begin
      din       = good[i];
      din_valid = 1'b1;
      din_last  = 1'b0;
      @(posedge clk); #1;
    end
    din_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("midrst_din_ready",  32'(din_ready),  32'd1);
    check("midrst_dout_valid", 32'(dout_valid), 32'd0);
    check("midrst_frame_len",  32'(frame_len),  32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("midrst_no_done", stat_q.size(), 0);
    out_q.delete();
    model_frame(good);
    send_frame(good, 1'b1, s1);
    verify("after_rst");

    for (int t = 0; t < 10; t++) begin
      rf.delete();
      repeat ($urandom_range(1, 18)) rf.push_back(8'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        c = crc_model(rf);
        rf.push_back(c[15:8]);
        rf.push_back(c[7:0]);
      end
      model_frame(rf);
      send_frame(rf, 1'b1, s1);
      verify("random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
